div32x16_seq: RTL



---
 rtl/div32x16_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/div32x16_seq.sv
// -----------------------------------------------------------------------------
// div32x16_seq
// Sequential unsigned 32-by-16 restoring divider. It produces one quotient bit
// per clock and uses valid/ready handshakes on both input and output.
// Operands with dividend < 256 take a shortened 8-iteration path. A zero
// divisor and a quotient too wide for 16 bits are both resolved on the accept
// edge and flagged.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active-high
//   in_valid     operands valid
//   in_ready     block can accept operands (high only in IDLE)
//   dividend     32-bit unsigned dividend
//   divisor      16-bit unsigned divisor
//   out_valid    result valid (high only in DONE)
//   out_ready    consumer accepts result
//   quotient     16-bit unsigned quotient
//   remainder    16-bit unsigned remainder
//   div_by_zero  divisor was zero
//   overflow     true quotient does not fit in 16 bits
// -----------------------------------------------------------------------------
module div32x16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [4:0]  cnt_q,       cnt_d;
    // Partial remainder. It always stays below the divisor, so 16 bits hold it;
    // the 17th bit only exists transiently in the shifted trial value.
    logic [15:0] rem_q,       rem_d;
    // Dividend bits still to be consumed, MSB first.
    logic [15:0] src_q,       src_d;
    logic [15:0] divisor_q,   divisor_d;
    logic [15:0] quo_q,       quo_d;
    logic [15:0] quotient_q,  quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        dbz_q,       dbz_d;
    logic        ovf_q,       ovf_d;

    logic [16:0] trial_s;
    logic [15:0] diff_s;
    logic        qbit_s;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            rem_q       <= 16'h0000;
            src_q       <= 16'h0000;
            divisor_q   <= 16'h0000;
            quo_q       <= 16'h0000;
            quotient_q  <= 16'h0000;
            remainder_q <= 16'h0000;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            src_q       <= src_d;
            divisor_q   <= divisor_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state, restoring-division step and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        src_d       = src_q;
        divisor_d   = divisor_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        trial_s = {rem_q, src_q[15]};
        qbit_s  = (trial_s >= {1'b0, divisor_q});
        // When the subtraction is taken the true difference is below the
        // divisor, so the low 16 bits of a modulo-2^16 subtract are exact.
        diff_s  = trial_s[15:0] - divisor_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    divisor_d = divisor;
                    if (divisor == 16'h0000) begin
                        state_d     = DONE;
                        quotient_d  = 16'hFFFF;
                        remainder_d = dividend[15:0];
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                    end else if (dividend[31:16] >= divisor) begin
                        state_d     = DONE;
                        quotient_d  = 16'hFFFF;
                        remainder_d = dividend[15:0];
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b1;
                    end else if (dividend[31:8] == 24'h000000) begin
                        // Left-justify the byte so the shift stays MSB first;
                        // quotient bits [15:8] remain 0 after 8 shifts.
                        state_d = CALC;
                        rem_d   = 16'h0000;
                        src_d   = {dividend[7:0], 8'h00};
                        cnt_d   = 5'd8;
                        quo_d   = 16'h0000;
                    end else begin
                        state_d = CALC;
                        rem_d   = dividend[31:16];
                        src_d   = dividend[15:0];
                        cnt_d   = 5'd16;
                        quo_d   = 16'h0000;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (qbit_s) begin
                    rem_d = diff_s;
                end else begin
                    rem_d = trial_s[15:0];
                end
                src_d = {src_q[14:0], 1'b0};
                quo_d = {quo_q[14:0], qbit_s};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d     = DONE;
                    quotient_d  = {quo_q[14:0], qbit_s};
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
